// File: rtl/speed_select_pkg.sv
// speed_select_pkg: shared types and step arithmetic for the operator speed selector.
//   SPEED_W     width of the speed divider value
//   CALC_W      internal arithmetic width (one guard bit above SPEED_W)
//   state_t     selector FSM states
//   step_speed  saturating increment/decrement of the speed value
package speed_select_pkg;

    localparam int unsigned SPEED_W = 11;
    localparam int unsigned CALC_W  = SPEED_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_t;

    // One step up or down, clamped to [smin, smax]; the guard bit keeps cur+step from wrapping.
    function automatic logic [SPEED_W-1:0] step_speed(
        input logic [SPEED_W-1:0] cur,
        input logic               up,
        input logic [CALC_W-1:0]  step,
        input logic [CALC_W-1:0]  smin,
        input logic [CALC_W-1:0]  smax
    );
        logic [CALC_W-1:0] c;
        logic [CALC_W-1:0] sum;
        logic [CALC_W-1:0] res;
        c   = {1'b0, cur};
        sum = c + step;
        if (up) begin
            res = (sum > smax) ? smax : sum;
        end else begin
            res = (c >= smin + step) ? (c - step) : smin;
        end
        return res[SPEED_W-1:0];
    endfunction

endpackage

// File: rtl/speed_select_btn_debounce.sv
// btn_debounce: two-flop synchroniser plus stability counter for one active-low button.
//   clk        system clock
//   rst        asynchronous active-low reset
//   i_btn_n    raw asynchronous button, low = pressed
//   o_press    registered one-cycle pulse on an accepted released->pressed transition
//   o_held_c   combinational: button accepted as pressed (and armed)
// A button is only armed once it has been seen released after reset, so a button
// held through reset never produces a press until it is let go and pressed again.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_press,
    output logic o_held_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]       r_sync;   // r_sync[1] is the synchronised level
    logic [1:0]       r_fill;   // marks when r_sync[1] reflects the real input after reset
    logic             r_level;  // accepted level, 1 = released
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_press;
    logic             w_flip;

    assign w_flip = (r_sync[1] != r_level) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Synchroniser, debounce counter, arming and press pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= 2'b11;
            r_fill  <= 2'b00;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn_n};
            r_fill <= {r_fill[0], 1'b1};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_press <= w_flip & r_level & r_armed;
            if (r_fill[1] && r_sync[1] && r_level) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_press  = r_press;
    assign o_held_c = r_armed & ~r_level;

endmodule

// File: rtl/speed_select.sv
// speed_select: operator speed selector driving an 11-bit divider value.
//   clk      system clock
//   rst      asynchronous active-low reset
//   btn_inc  raw button, low = pressed, steps speed up
//   btn_dec  raw button, low = pressed, steps speed down
//   speed    registered divider value
//   changed  one-cycle pulse when speed takes a new value
//   at_min   registered speed == SPEED_MIN
//   at_max   registered speed == SPEED_MAX
// Build option: define SPEED_SELECT_REPEAT_EN to enable hold-to-repeat stepping.
module speed_select
    import speed_select_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned STEP            = 8,
    parameter int unsigned SPEED_MIN       = 16,
    parameter int unsigned SPEED_MAX       = 2047,
    parameter int unsigned SPEED_INIT      = 124,
    parameter int unsigned REPEAT_DELAY    = 6000000,
    parameter int unsigned REPEAT_RATE     = 1200000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_inc,
    input  logic               btn_dec,
    output logic [SPEED_W-1:0] speed,
    output logic               changed,
    output logic               at_min,
    output logic               at_max
);

    // Elaboration-time parameter sanity checks.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("speed_select: DEBOUNCE_CYCLES must be at least 2");
    end
    if (SPEED_MAX > 2047 || SPEED_MAX <= SPEED_MIN) begin : g_bad_range
        $error("speed_select: SPEED_MAX out of range");
    end
    if (SPEED_INIT < SPEED_MIN || SPEED_INIT > SPEED_MAX) begin : g_bad_init
        $error("speed_select: SPEED_INIT out of range");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("speed_select: repeat timings must be non-zero");
    end

    localparam logic [SPEED_W-1:0] INIT_VAL = SPEED_W'(SPEED_INIT);
    localparam logic [SPEED_W-1:0] MIN_VAL  = SPEED_W'(SPEED_MIN);
    localparam logic [SPEED_W-1:0] MAX_VAL  = SPEED_W'(SPEED_MAX);

    logic w_inc_press;
    logic w_inc_held;
    logic w_dec_press;
    logic w_dec_held;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk      (clk),
        .rst      (rst),
        .i_btn_n  (btn_inc),
        .o_press  (w_inc_press),
        .o_held_c (w_inc_held)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
        .clk      (clk),
        .rst      (rst),
        .i_btn_n  (btn_dec),
        .o_press  (w_dec_press),
        .o_held_c (w_dec_held)
    );

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_dir;          // 1 = inc button is the held one
    logic               w_dir_nxt;
    logic [SPEED_W-1:0] r_speed;
    logic [SPEED_W-1:0] w_speed_nxt;
    logic               r_changed;
    logic               r_at_min;
    logic               r_at_max;

    logic [SPEED_W-1:0] w_up;
    logic [SPEED_W-1:0] w_dn;
    logic               w_dir_held;
    logic               w_both_held;

    assign w_up        = step_speed(r_speed, 1'b1, CALC_W'(STEP), CALC_W'(SPEED_MIN), CALC_W'(SPEED_MAX));
    assign w_dn        = step_speed(r_speed, 1'b0, CALC_W'(STEP), CALC_W'(SPEED_MIN), CALC_W'(SPEED_MAX));
    assign w_dir_held  = r_dir ? w_inc_held : w_dec_held;
    assign w_both_held = w_inc_held & w_dec_held;

`ifdef SPEED_SELECT_REPEAT_EN
    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [SPEED_W-1:0] w_step_held;

    assign w_step_held = r_dir ? w_up : w_dn;
`endif

    // Next-state, next-speed and repeat timer.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_speed_nxt = r_speed;
`ifdef SPEED_SELECT_REPEAT_EN
        w_timer_nxt = '0;
`endif
        case (r_state)
            IDLE: begin
                if ((w_inc_press && (w_dec_press || w_dec_held)) || (w_dec_press && w_inc_held)) begin
                    w_speed_nxt = INIT_VAL;
                    w_state_nxt = LOCK;
                end else if (w_inc_press) begin
                    w_speed_nxt = w_up;
                    w_dir_nxt   = 1'b1;
                    w_state_nxt = HOLD;
                end else if (w_dec_press) begin
                    w_speed_nxt = w_dn;
                    w_dir_nxt   = 1'b0;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_both_held) begin
                    w_speed_nxt = INIT_VAL;
                    w_state_nxt = LOCK;
                end else if (!w_dir_held) begin
                    w_state_nxt = IDLE;
`ifdef SPEED_SELECT_REPEAT_EN
                end else if (r_timer == TMR_W'(REPEAT_DELAY - 1)) begin
                    // Delay elapsed: first repeat step lands here.
                    w_speed_nxt = w_step_held;
                    w_state_nxt = REPEAT;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
`endif
                end
            end
            REPEAT: begin
`ifdef SPEED_SELECT_REPEAT_EN
                if (w_both_held) begin
                    w_speed_nxt = INIT_VAL;
                    w_state_nxt = LOCK;
                end else if (!w_dir_held) begin
                    w_state_nxt = IDLE;
                end else if (r_timer == TMR_W'(REPEAT_RATE - 1)) begin
                    w_speed_nxt = w_step_held;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            LOCK: begin
                if (!w_inc_held && !w_dec_held) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_dir     <= 1'b0;
            r_speed   <= INIT_VAL;
            r_changed <= 1'b0;
            r_at_min  <= (INIT_VAL == MIN_VAL);
            r_at_max  <= (INIT_VAL == MAX_VAL);
        end else begin
            r_state   <= w_state_nxt;
            r_dir     <= w_dir_nxt;
            r_speed   <= w_speed_nxt;
            r_changed <= (w_speed_nxt != r_speed);
            r_at_min  <= (w_speed_nxt == MIN_VAL);
            r_at_max  <= (w_speed_nxt == MAX_VAL);
        end
    end

`ifdef SPEED_SELECT_REPEAT_EN
    // Hold / repeat interval timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_timer_nxt;
        end
    end
`endif

    assign speed   = r_speed;
    assign changed = r_changed;
    assign at_min  = r_at_min;
    assign at_max  = r_at_max;

endmodule

// File: tb/tb_speed_select.sv
// tb_speed_select: directed self-checking bench for speed_select with small timing parameters.
module tb_speed_select;

    logic        clk;
    logic        rst;
    logic        btn_inc;
    logic        btn_dec;
    logic [10:0] speed;
    logic        changed;
    logic        at_min;
    logic        at_max;

    int checks = 0;
    int errors = 0;
    int chg_cnt = 0;
    int base = 0;

    speed_select #(
        .DEBOUNCE_CYCLES (4),
        .STEP            (8),
        .SPEED_MIN       (16),
        .SPEED_MAX       (40),
        .SPEED_INIT      (24),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_inc (btn_inc),
        .btn_dec (btn_dec),
        .speed   (speed),
        .changed (changed),
        .at_min  (at_min),
        .at_max  (at_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count changed pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst && changed === 1'b1) chg_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full press: hold 8 cycles (accepted after 7), release and let it settle.
    task automatic press(input bit inc);
        if (inc) btn_inc = 1'b0;
        else     btn_dec = 1'b0;
        tick(8);
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        tick(8);
    endtask

`ifdef SPEED_SELECT_REPEAT_EN
    localparam int R1 = 32;
    localparam int R2 = 40;
`else
    localparam int R1 = 24;
    localparam int R2 = 24;
`endif

    initial begin
        rst     = 1'b0;
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        tick(3);
        check("rst_speed", 32'(speed), 32'd24);
        check("rst_changed", 32'(changed), 32'd0);
        check("rst_at_min", 32'(at_min), 32'd0);
        check("rst_at_max", 32'(at_max), 32'd0);
        rst = 1'b1;
        tick(5);
        check("idle_speed", 32'(speed), 32'd24);
        check("idle_changed", 32'(changed), 32'd0);

        // Held inc: step lands exactly on the 7th edge.
        base = chg_cnt;
        btn_inc = 1'b0;
        tick(6);
        check("lat_edge6", 32'(speed), 32'd24);
        tick(1);
        check("lat_edge7", 32'(speed), 32'd32);
        check("lat_changed", 32'(changed), 32'd1);
        tick(1);
        check("lat_changed_drop", 32'(changed), 32'd0);
        check("lat_pulses", 32'(chg_cnt - base), 32'd1);
        btn_inc = 1'b1;
        tick(10);

        // 3-cycle glitch is ignored.
        base = chg_cnt;
        btn_inc = 1'b0;
        tick(3);
        btn_inc = 1'b1;
        tick(10);
        check("glitch_speed", 32'(speed), 32'd32);
        check("glitch_pulses", 32'(chg_cnt - base), 32'd0);

        // Saturate at max.
        base = chg_cnt;
        press(1'b1);
        check("to_max", 32'(speed), 32'd40);
        check("to_max_pulses", 32'(chg_cnt - base), 32'd1);
        base = chg_cnt;
        press(1'b1);
        check("sat_max", 32'(speed), 32'd40);
        check("sat_max_pulses", 32'(chg_cnt - base), 32'd0);
        check("sat_at_max", 32'(at_max), 32'd1);

        // Six decs saturate at min.
        base = chg_cnt;
        for (int i = 0; i < 6; i++) press(1'b0);
        check("sat_min", 32'(speed), 32'd16);
        check("sat_at_min", 32'(at_min), 32'd1);
        check("sat_min_at_max", 32'(at_max), 32'd0);
        check("sat_min_pulses", 32'(chg_cnt - base), 32'd3);

        // Both pressed restores init and locks.
        press(1'b1);
        check("pre_lock", 32'(speed), 32'd24);
        btn_dec = 1'b0;
        tick(8);
        check("lock_dec", 32'(speed), 32'd16);
        btn_inc = 1'b0;
        tick(8);
        check("lock_init", 32'(speed), 32'd24);
        btn_inc = 1'b1;
        tick(8);
        btn_inc = 1'b0;
        tick(8);
        check("lock_no_step", 32'(speed), 32'd24);
        btn_inc = 1'b1;
        tick(8);
        btn_dec = 1'b1;
        tick(8);
        check("lock_released", 32'(speed), 32'd24);
        press(1'b1);
        check("post_lock_step", 32'(speed), 32'd32);

        // Hold-to-repeat from the minimum.
        press(1'b0);
        press(1'b0);
        check("rep_start", 32'(speed), 32'd16);
        btn_inc = 1'b0;
        tick(7);
        check("rep_first", 32'(speed), 32'd24);
        tick(19);
        check("rep_before_delay", 32'(speed), 32'd24);
        tick(1);
        check("rep_delay", 32'(speed), 32'(R1));
        tick(4);
        check("rep_before_rate", 32'(speed), 32'(R1));
        tick(1);
        check("rep_rate", 32'(speed), 32'(R2));
        tick(10);
        check("rep_hold", 32'(speed), 32'(R2));

        // Asynchronous reset while held; no step on release of reset.
        rst = 1'b0;
        #1;
        check("async_rst_speed", 32'(speed), 32'd24);
        check("async_rst_at_max", 32'(at_max), 32'd0);
        tick(3);
        rst = 1'b1;
        base = chg_cnt;
        tick(20);
        check("held_thru_rst", 32'(speed), 32'd24);
        check("held_thru_rst_pulses", 32'(chg_cnt - base), 32'd0);
        btn_inc = 1'b1;
        tick(10);
        check("rst_release", 32'(speed), 32'd24);
        base = chg_cnt;
        press(1'b1);
        check("rst_repress", 32'(speed), 32'd32);
        check("rst_repress_pulses", 32'(chg_cnt - base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
